// File: rtl/rca_cmp_pipe.sv
// rca_cmp_pipe: pipelined ripple-carry add/subtract unit with unsigned compare.
// The operand path is cut into STAGES slices of WIDTH/STAGES bits. Each slice
// has one register boundary, and the carry ripples between slice registers.
// WIDTH must be a multiple of STAGES.
// Optional feature: define RCA_OVF_EN to add the signed-overflow output OVF.
module rca_cmp_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             EQ,
    output logic             GT,
    output logic             LT,
`ifdef RCA_OVF_EN
    output logic             OVF,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int unsigned SW = WIDTH / STAGES;

    // Stage k holds finished sum bits [0 +: (k+1)*SW], its slice carry, the
    // operands still to be consumed and the comparator flags {eq, gt, lt}.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][2:0]       flg_q, flg_d;
`ifdef RCA_OVF_EN
    logic                         ovf_q, ovf_d;
`endif

    // Inputs seen by each stage: the unit's ports for stage 0, else the previous register
    logic [STAGES-1:0]            src_valid;
    logic [STAGES-1:0]            src_c;
    logic [STAGES-1:0][WIDTH-1:0] src_a;
    logic [STAGES-1:0][WIDTH-1:0] src_b;
    logic [STAGES-1:0][WIDTH-1:0] src_sum;
    logic [STAGES-1:0][2:0]       src_flg;

    logic [SW-1:0]                sl_a;
    logic [SW-1:0]                sl_b;
    logic [SW:0]                  sl_sum;
    logic                         stall;
    logic                         advance;
    logic                         unused_ops;

    // Global stall: a result is waiting and the consumer is not taking it
    always_comb begin
        stall    = valid_q[STAGES-1] & ~OUT_READY;
        advance  = ~stall;
        IN_READY = advance;
    end

    // Route the port operands into stage 0 and each register into the next stage
    always_comb begin
        src_valid[0] = IN_VALID;
        src_a[0]     = A;
        src_b[0]     = B ^ {WIDTH{SUB}};
        src_sum[0]   = '0;
        src_c[0]     = SUB;
        src_flg[0]   = {A == B, A > B, A < B};
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_c[k]     = c_q[k-1];
            src_flg[k]   = flg_q[k-1];
        end
    end

    // Slice adders and next-state logic. Data registers only load real
    // operands, so S and the flags keep their last value once the pipe drains.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        flg_d   = flg_q;
`ifdef RCA_OVF_EN
        ovf_d   = ovf_q;
`endif
        sl_a    = '0;
        sl_b    = '0;
        sl_sum  = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sl_a   = src_a[k][k*SW +: SW];
            sl_b   = src_b[k][k*SW +: SW];
            sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{SW{1'b0}}, src_c[k]};
            if (advance) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    a_d[k]              = src_a[k];
                    b_d[k]              = src_b[k];
                    sum_d[k]            = src_sum[k];
                    sum_d[k][k*SW +: SW] = sl_sum[SW-1:0];
                    c_d[k]              = sl_sum[SW];
                    flg_d[k]            = src_flg[k];
`ifdef RCA_OVF_EN
                    // carry into the MSB is recovered from the MSB sum bit
                    if (k == STAGES - 1) begin
                        ovf_d = sl_a[SW-1] ^ sl_b[SW-1] ^ sl_sum[SW-1] ^ sl_sum[SW];
                    end
`endif
                end
            end
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight results are discarded
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= '0;
            flg_q   <= '0;
`ifdef RCA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            flg_q   <= flg_d;
`ifdef RCA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Result outputs come straight from the last stage
    always_comb begin
        S          = sum_q[STAGES-1];
        Cout       = c_q[STAGES-1];
        EQ         = flg_q[STAGES-1][2];
        GT         = flg_q[STAGES-1][1];
        LT         = flg_q[STAGES-1][0];
        OUT_VALID  = valid_q[STAGES-1];
`ifdef RCA_OVF_EN
        OVF        = ovf_q;
`endif
        // the last stage has no slice left to consume its operand copy
        unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};
    end

endmodule

// File: tb/tb_rca_cmp_pipe.sv
// Testbench for rca_cmp_pipe: a 4-bit/2-stage instance driven from a vector
// table plus corner sequences, and a 16-bit/4-stage instance with random
// operands and random OUT_READY. Results are checked through scoreboards.
`timescale 1ns/1ps
module tb_rca_cmp_pipe;

    localparam int unsigned NV   = 12;
    localparam logic [2:0]  F_EQ = 3'b100;
    localparam logic [2:0]  F_GT = 3'b010;
    localparam logic [2:0]  F_LT = 3'b001;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] s;
        logic       c;
        logic [2:0] flg;
        logic       ovf;
    } vec4_t;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic [2:0]  flg;
        logic        ovf;
    } exp16_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a4, b4, s4;
    logic        sub4, iv4, ir4, co4, eq4, gt4, lt4, ov4, or4;
    logic [15:0] a16, b16, s16;
    logic        sub16, iv16, ir16, co16, eq16, gt16, lt16, ov16, or16;
`ifdef RCA_OVF_EN
    logic        ovf4, ovf16;
`endif

    int     checks = 0;
    int     errors = 0;
    vec4_t  tbl [NV];
    vec4_t  q4 [$];
    exp16_t q16 [$];
    vec4_t  e4;
    exp16_t e16;
    logic [9:0]  act4, exp4;
    logic [21:0] act16, exp16;
    logic        done16;
    logic [15:0] ra, rb;
    logic        rs;
    int unsigned run4;

    rca_cmp_pipe #(.WIDTH(4), .STAGES(2)) u_dut4 (
        .CLK(clk), .RST(rst), .A(a4), .B(b4), .SUB(sub4),
        .IN_VALID(iv4), .IN_READY(ir4), .S(s4), .Cout(co4),
        .EQ(eq4), .GT(gt4), .LT(lt4),
`ifdef RCA_OVF_EN
        .OVF(ovf4),
`endif
        .OUT_VALID(ov4), .OUT_READY(or4)
    );

    rca_cmp_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .SUB(sub16),
        .IN_VALID(iv16), .IN_READY(ir16), .S(s16), .Cout(co16),
        .EQ(eq16), .GT(gt16), .LT(lt16),
`ifdef RCA_OVF_EN
        .OVF(ovf16),
`endif
        .OUT_VALID(ov16), .OUT_READY(or16)
    );

    function automatic vec4_t mk(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                 input logic [3:0] s, input logic c, input logic [2:0] f,
                                 input logic ovf);
        mk = {a, b, sub, s, c, f, ovf};
    endfunction

    function automatic exp16_t model16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] full;
        full = sub ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
        model16.s   = full[15:0];
        model16.c   = full[16];
        model16.flg = (a == b) ? F_EQ : ((a > b) ? F_GT : F_LT);
        model16.ovf = sub ? ((a[15] != b[15]) && (full[15] != a[15]))
                          : ((a[15] == b[15]) && (full[15] != a[15]));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic send4(input vec4_t v);
        int unsigned g = 0;
        bit acc = 1'b0;
        a4 = v.a; b4 = v.b; sub4 = v.sub; iv4 = 1'b1;
        while (!acc && g < 50) begin
            @(negedge clk);
            if (ir4) begin
                acc = 1'b1;
                q4.push_back(v);
            end
            @(posedge clk); #1;
            g++;
        end
        iv4 = 1'b0;
        if (!acc) timeout("send4");
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int unsigned g = 0;
        bit acc = 1'b0;
        a16 = a; b16 = b; sub16 = sub; iv16 = 1'b1;
        while (!acc && g < 200) begin
            @(negedge clk);
            if (ir16) begin
                acc = 1'b1;
                q16.push_back(model16(a, b, sub));
            end
            @(posedge clk); #1;
            g++;
        end
        iv16 = 1'b0;
        if (!acc) timeout("send16");
    endtask

    task automatic lat4(input vec4_t v);
        int unsigned n = 1;
        send4(v);
        while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
        check("latency4", 64'(n), 64'd2);
    endtask

    task automatic lat16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int unsigned n = 1;
        send16(a, b, sub);
        while (!ov16 && n < 20) begin @(posedge clk); #1; n++; end
        check("latency16", 64'(n), 64'd4);
    endtask

    task automatic drain4();
        int unsigned g = 0;
        while (q4.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
        check("drain4_empty", 64'(q4.size()), 64'd0);
        @(posedge clk); #1;
        check("drain4_idle", 64'(ov4), 64'd0);
    endtask

    task automatic drain16();
        int unsigned g = 0;
        while (q16.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
        check("drain16_empty", 64'(q16.size()), 64'd0);
        @(posedge clk); #1;
        check("drain16_idle", 64'(ov16), 64'd0);
    endtask

    // Scoreboard for the 4-bit instance: compare each result as it is consumed
    always @(negedge clk) begin
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out4_unexpected: got S=%b with no result pending", s4);
            end else begin
                e4 = q4.pop_front();
`ifdef RCA_OVF_EN
                act4 = {1'b0, s4, co4, eq4, gt4, lt4, ovf4};
                exp4 = {1'b0, e4.s, e4.c, e4.flg, e4.ovf};
`else
                act4 = {1'b0, s4, co4, eq4, gt4, lt4, 1'b0};
                exp4 = {1'b0, e4.s, e4.c, e4.flg, 1'b0};
`endif
                check("result4 {S,C,EQ,GT,LT,OVF}", 64'(act4), 64'(exp4));
            end
        end
    end

    // Scoreboard for the 16-bit instance
    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out16_unexpected: got S=%h with no result pending", s16);
            end else begin
                e16 = q16.pop_front();
`ifdef RCA_OVF_EN
                act16 = {s16, co16, eq16, gt16, lt16, ovf16};
                exp16 = {e16.s, e16.c, e16.flg, e16.ovf};
`else
                act16 = {s16, co16, eq16, gt16, lt16, 1'b0};
                exp16 = {e16.s, e16.c, e16.flg, 1'b0};
`endif
                check("result16 {S,C,EQ,GT,LT,OVF}", 64'(act16), 64'(exp16));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a4 = '0; b4 = '0; sub4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
        a16 = '0; b16 = '0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
        done16 = 1'b0;

        tbl[0]  = mk(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, F_LT, 1'b0);
        tbl[1]  = mk(4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, F_EQ, 1'b0);
        tbl[2]  = mk(4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, F_EQ, 1'b1);
        tbl[3]  = mk(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, F_EQ, 1'b0);
        tbl[4]  = mk(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, F_EQ, 1'b1);
        tbl[5]  = mk(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, F_LT, 1'b0);
        tbl[6]  = mk(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, F_GT, 1'b0);
        tbl[7]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, F_EQ, 1'b0);
        tbl[8]  = mk(4'b0111, 4'b1111, 1'b0, 4'b0110, 1'b1, F_LT, 1'b0);
        tbl[9]  = mk(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, F_GT, 1'b1);
        tbl[10] = mk(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, F_GT, 1'b1);
        tbl[11] = mk(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, F_GT, 1'b0);

        // reset state
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out4", 64'({ov4, s4, co4, eq4, gt4, lt4}), 64'd0);
        check("reset_out16", 64'({ov16, s16, co16, eq16, gt16, lt16}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready4", 64'(ir4), 64'd1);

        // single accept: latency and first result
        lat4(tbl[0]);
        drain4();

        // back-to-back vectors must come out with no bubbles
        fork
            begin
                for (int i = 1; i < NV; i++) send4(tbl[i]);
            end
            begin
                int unsigned g = 0;
                run4 = 0;
                @(negedge clk);
                while (!ov4 && g < 20) begin @(negedge clk); g++; end
                while (ov4 && run4 < 100) begin run4++; @(negedge clk); end
            end
        join
        check("no_bubbles_run4", 64'(run4), 64'(NV - 1));
        drain4();

        // backpressure: hold OUT_READY low for 3 cycles with a result waiting
        send4(tbl[2]);
        send4(tbl[5]);
        check("bp_valid4", 64'(ov4), 64'd1);
        or4 = 1'b0;
        fork
            send4(tbl[9]);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready4", 64'(ir4), 64'd0);
                    check("bp_hold4", 64'({s4, co4, eq4, gt4, lt4}),
                          64'({q4[0].s, q4[0].c, q4[0].flg}));
                end
                @(posedge clk); #1;
                or4 = 1'b1;
            end
        join
        drain4();

        // asynchronous reset with two results in flight
        send4(tbl[3]);
        send4(tbl[6]);
        #1 rst = 1'b1;
        #1;
        check("rst_async_out4", 64'({ov4, s4, co4, eq4, gt4, lt4}), 64'd0);
        check("rst_in_ready4", 64'(ir4), 64'd1);
        q4.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_stale4", 64'(ov4), 64'd0);
        lat4(tbl[7]);
        drain4();

        // 16-bit / 4-stage instance: latency, then random traffic with random OUT_READY
        lat16(16'h1234, 16'h0FFF, 1'b1);
        drain16();
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    case ($urandom_range(0, 7))
                        0: rb = ra;
                        1: begin ra = '0; rb = '0; end
                        2: ra = 16'hFFFF;
                        3: rb = 16'hFFFF;
                        default: ;
                    endcase
                    rs = 1'($urandom_range(0, 1));
                    send16(ra, rb, rs);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done16 = 1'b1;
            end
            begin
                int unsigned g = 0;
                while (!done16 && g < 20000) begin
                    or16 = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    g++;
                end
                or16 = 1'b1;
            end
        join
        drain16();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
